jtframe_ddr_arb: RTL and testbench

// - Shares the single DDR3 Avalon-style port between two masters: port A (line frame buffer

---
 rtl/jtframe_ddr_arb.sv | 227 ++++++++++++++++++++++
 tb/tb_jtframe_ddr_arb.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_ddr_arb.sv
// Two-master burst arbiter in front of the DDR3 Avalon-style bridge: port A (frame buffer,
// high priority) and port B (general client). Optional B anti-starvation: JTFRAME_DDRARB_FAIR_EN.
module jtframe_ddr_arb #(
  parameter int AW    = 29,
  parameter int DW    = 64,
  parameter int FAIRN = 4
)(
  input  logic            rst,
  input  logic            clk,
  // port A
  input  logic [AW-1:0]   a_addr,
  input  logic [7:0]      a_burstcnt,
  input  logic            a_rd,
  input  logic            a_we,
  input  logic [DW-1:0]   a_din,
  input  logic [DW/8-1:0] a_be,
  output logic            a_busy,
  output logic            a_dout_ready,
  output logic [DW-1:0]   a_dout,
  // port B
  input  logic [AW-1:0]   b_addr,
  input  logic [7:0]      b_burstcnt,
  input  logic            b_rd,
  input  logic            b_we,
  input  logic [DW-1:0]   b_din,
  input  logic [DW/8-1:0] b_be,
  output logic            b_busy,
  output logic            b_dout_ready,
  output logic [DW-1:0]   b_dout,
  // DDR bridge
  output logic            ddram_clk,
  output logic [AW-1:0]   ddram_addr,
  output logic [7:0]      ddram_burstcnt,
  output logic            ddram_rd,
  output logic            ddram_we,
  output logic [DW-1:0]   ddram_din,
  output logic [DW/8-1:0] ddram_be,
  input  logic            ddram_busy,
  input  logic [DW-1:0]   ddram_dout,
  input  logic            ddram_dout_ready,
  // debug
  output logic [1:0]      owner
);

  // Handshake: a command/beat (rd or we) is transferred on a rising edge where it is
  // asserted and the matching busy is low; the requester holds it steady until then.
  // Read beats are valid on any edge where dout_ready is high (no back-pressure).

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR     = 2'd1,
    ST_RDCMD  = 2'd2,
    ST_RDDATA = 2'd3
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [8:0]  len_q, len_d;

  logic            a_req, b_req;
  logic            grant_b, fair_hit;
  logic            fwd;
  logic [AW-1:0]   m_addr;
  logic [7:0]      m_burstcnt;
  logic            m_rd, m_we;
  logic [DW-1:0]   m_din;
  logic [DW/8-1:0] m_be;
  logic [8:0]      eff_len;

  function automatic logic [8:0] burst_len(input logic [7:0] bc);
    burst_len = (bc == 8'd0) ? 9'd256 : {1'b0, bc};
  endfunction

  assign a_req   = a_rd | a_we;
  assign b_req   = b_rd | b_we;
  assign grant_b = (state_q == ST_IDLE) && b_req && (!a_req || fair_hit);

`ifdef JTFRAME_DDRARB_FAIR_EN
  localparam int              FW       = $clog2(FAIRN + 1);
  localparam logic [FW-1:0]   FAIR_MAX = FW'(FAIRN);

  logic          grant_a;
  logic [FW-1:0] fair_q;

  assign grant_a  = (state_q == ST_IDLE) && a_req && !grant_b;
  assign fair_hit = (fair_q >= FAIR_MAX);

  // Consecutive A grants taken while B was waiting; saturates at FAIRN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fair_q <= '0;
    end else if (!b_req || grant_b) begin
      fair_q <= '0;
    end else if (grant_a && !fair_hit) begin
      fair_q <= fair_q + 1'b1;
    end
  end
`else
  // Strict A priority: the fairness override never fires.
  assign fair_hit = (FAIRN < 0);
`endif

  // Granted master's request lines.
  always_comb begin
    m_addr     = '0;
    m_burstcnt = '0;
    m_rd       = 1'b0;
    m_we       = 1'b0;
    m_din      = '0;
    m_be       = '0;
    case (owner_q)
      OWN_A: begin
        m_addr     = a_addr;
        m_burstcnt = a_burstcnt;
        m_rd       = a_rd;
        m_we       = a_we;
        m_din      = a_din;
        m_be       = a_be;
      end
      OWN_B: begin
        m_addr     = b_addr;
        m_burstcnt = b_burstcnt;
        m_rd       = b_rd;
        m_we       = b_we;
        m_din      = b_din;
        m_be       = b_be;
      end
      default: ;
    endcase
  end

  // The first write beat carries the burst length; later beats use the latched copy.
  assign eff_len = (cnt_q == 9'd0) ? burst_len(m_burstcnt) : len_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (a_req || b_req) begin
          owner_d = grant_b ? OWN_B : OWN_A;
          cnt_d   = 9'd0;
          if (grant_b ? b_rd : a_rd) state_d = ST_RDCMD;
          else                       state_d = ST_WR;
        end
      end
      ST_WR: begin
        if (m_we && !ddram_busy) begin
          if (cnt_q == 9'd0) len_d = burst_len(m_burstcnt);
          if (cnt_q + 9'd1 == eff_len) begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
            cnt_d   = 9'd0;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      ST_RDCMD: begin
        if (m_rd && !ddram_busy) begin
          len_d   = burst_len(m_burstcnt);
          cnt_d   = 9'd0;
          state_d = ST_RDDATA;
        end
      end
      ST_RDDATA: begin
        if (ddram_dout_ready) begin
          if (cnt_q + 9'd1 == len_q) begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
            cnt_d   = 9'd0;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        cnt_d   = 9'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      cnt_q   <= 9'd0;
      len_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Command path is only open while the owner may still issue rd/we beats.
  assign fwd = (state_q == ST_WR) || (state_q == ST_RDCMD);

  assign ddram_clk      = clk;
  assign ddram_addr     = m_addr;
  assign ddram_burstcnt = m_burstcnt;
  assign ddram_din      = m_din;
  assign ddram_be       = m_be;
  assign ddram_we       = (state_q == ST_WR)    && m_we;
  assign ddram_rd       = (state_q == ST_RDCMD) && m_rd;

  assign a_busy = (fwd && owner_q == OWN_A) ? ddram_busy : 1'b1;
  assign b_busy = (fwd && owner_q == OWN_B) ? ddram_busy : 1'b1;

  assign a_dout_ready = (state_q == ST_RDDATA) && (owner_q == OWN_A) && ddram_dout_ready;
  assign b_dout_ready = (state_q == ST_RDDATA) && (owner_q == OWN_B) && ddram_dout_ready;
  assign a_dout       = ddram_dout;
  assign b_dout       = ddram_dout;

  assign owner = owner_q;

endmodule

// File: tb/tb_jtframe_ddr_arb.sv
// Bench for jtframe_ddr_arb: transaction-level model of grants/bursts, write-data
// scoreboard, DDR read responder and directed scenarios with literal expectations.
module tb_jtframe_ddr_arb;
  localparam int AW = 29;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int FAIRN = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [1:0]    rd_v = '0, we_v = '0;
  logic [AW-1:0] addr_v [2];
  logic [7:0]    bc_v   [2];
  logic [DW-1:0] din_v  [2];
  logic [BW-1:0] be_v   [2];
  logic          a_busy, b_busy, a_dout_ready, b_dout_ready;
  logic [DW-1:0] a_dout, b_dout;
  logic          ddram_clk, ddram_rd, ddram_we;
  logic [AW-1:0] ddram_addr;
  logic [7:0]    ddram_burstcnt;
  logic [DW-1:0] ddram_din;
  logic [BW-1:0] ddram_be;
  logic          ddram_busy = 1'b0;
  logic [DW-1:0] ddram_dout = '0;
  logic          ddram_dout_ready = 1'b0;
  logic [1:0]    owner;
  logic [1:0]    busy_v, dr_v;

  assign busy_v = {b_busy, a_busy};
  assign dr_v   = {b_dout_ready, a_dout_ready};

  jtframe_ddr_arb #(.AW(AW), .DW(DW), .FAIRN(FAIRN)) dut (
    .rst(rst), .clk(clk),
    .a_addr(addr_v[0]), .a_burstcnt(bc_v[0]), .a_rd(rd_v[0]), .a_we(we_v[0]),
    .a_din(din_v[0]), .a_be(be_v[0]), .a_busy(a_busy), .a_dout_ready(a_dout_ready),
    .a_dout(a_dout),
    .b_addr(addr_v[1]), .b_burstcnt(bc_v[1]), .b_rd(rd_v[1]), .b_we(we_v[1]),
    .b_din(din_v[1]), .b_be(be_v[1]), .b_busy(b_busy), .b_dout_ready(b_dout_ready),
    .b_dout(b_dout),
    .ddram_clk(ddram_clk), .ddram_addr(ddram_addr), .ddram_burstcnt(ddram_burstcnt),
    .ddram_rd(ddram_rd), .ddram_we(ddram_we), .ddram_din(ddram_din), .ddram_be(ddram_be),
    .ddram_busy(ddram_busy), .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready),
    .owner(owner)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW+BW-1:0] exp_q[$];
  int glog[$];
  int wr_beats = 0;
  int b_dr_while_a = 0;
  int busy_mode = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int blen(input logic [7:0] bc);
    return (bc == 8'd0) ? 256 : int'(bc);
  endfunction

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 write burst, 2 read command pending, 3 read data
  int m_owner = 0, m_phase = 0, m_left = 0, m_fair = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_owner = 0; m_phase = 0; m_left = 0; m_fair = 0;
      end else begin
        automatic bit a_req = rd_v[0] | we_v[0];
        automatic bit b_req = rd_v[1] | we_v[1];
        automatic int o = (m_owner > 0) ? m_owner - 1 : 0;
        automatic bit take_b;
`ifdef JTFRAME_DDRARB_FAIR_EN
        take_b = b_req && (!a_req || m_fair >= FAIRN);
`else
        take_b = b_req && !a_req;
`endif
        if (!b_req || (m_phase == 0 && take_b)) m_fair = 0;
        else if (m_phase == 0 && a_req && m_fair < FAIRN) m_fair++;
        case (m_phase)
          0: if (a_req || b_req) begin
            automatic int w = take_b ? 1 : 0;
            m_owner = w + 1;
            m_phase = rd_v[w] ? 2 : 1;
            m_left  = -1;
          end
          1: if (we_v[o] && !ddram_busy) begin
            if (m_left < 0) m_left = blen(bc_v[o]);
            m_left--;
            if (m_left == 0) begin m_phase = 0; m_owner = 0; end
          end
          2: if (rd_v[o] && !ddram_busy) begin
            m_left = blen(bc_v[o]);
            m_phase = 3;
          end
          default: if (ddram_dout_ready) begin
            m_left--;
            if (m_left == 0) begin m_phase = 0; m_owner = 0; end
          end
        endcase
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    int prev_owner = 0;
    forever begin
      @(negedge clk);
      begin
        automatic int o = (m_owner > 0) ? m_owner - 1 : 0;
        automatic bit own = (m_owner != 0);
        automatic bit fw  = own && (m_phase == 1 || m_phase == 2);
        chk("owner", owner, m_owner);
        chk("ddram_we", ddram_we, own && m_phase == 1 && we_v[o]);
        chk("ddram_rd", ddram_rd, own && m_phase == 2 && rd_v[o]);
        for (int p = 0; p < 2; p++) begin
          chk("busy", busy_v[p], (fw && o == p) ? ddram_busy : 1'b1);
          chk("dout_ready", dr_v[p], (own && m_phase == 3 && o == p) ? ddram_dout_ready : 1'b0);
        end
        if (fw) begin
          chk("ddram_addr", ddram_addr, addr_v[o]);
          chk("ddram_burstcnt", ddram_burstcnt, bc_v[o]);
        end
        if (b_dout_ready && m_owner == 1) b_dr_while_a++;
        if (ddram_we && !ddram_busy) begin
          wr_beats++;
          if (exp_q.size() == 0) chk("wr_unexpected", {ddram_be, ddram_din}, '0);
          else chk("wr_data", {ddram_be, ddram_din}, exp_q.pop_front());
        end
        if (owner != 0 && prev_owner == 0) glog.push_back(int'(owner));
        prev_owner = int'(owner);
      end
    end
  end

  // ---------------- DDR bridge stand-in ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      case (busy_mode)
        0:       ddram_busy = 1'b0;
        1:       ddram_busy = ~ddram_busy;
        default: ddram_busy = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  initial begin
    int rd_left = 0;
    bit rd_acc;
    logic [7:0] bc_s;
    logic [DW-1:0] word = 64'h1000;
    forever begin
      @(negedge clk);
      rd_acc = ddram_rd && !ddram_busy && !rst;
      bc_s   = ddram_burstcnt;
      @(posedge clk); #1;
      if (rst) begin
        rd_left = 0;
        ddram_dout_ready = 1'b0;
      end else begin
        if (rd_acc) rd_left += blen(bc_s);
        if (rd_left > 0 && $urandom_range(0, 3) != 0) begin
          ddram_dout_ready = 1'b1;
          ddram_dout = word;
          word++;
          rd_left--;
        end else begin
          ddram_dout_ready = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept(input int p, output bit ok);
    bit b;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      b = busy_v[p];
      @(posedge clk); #1;
      if (!b) begin ok = 1'b1; return; end
    end
    chk("accept_timeout", 0, 1);
  endtask

  task automatic m_write(input int p, input int nbeats, input logic [7:0] bc,
                         input logic [AW-1:0] addr);
    bit ok;
    for (int i = 0; i < nbeats; i++) begin
      addr_v[p] = addr;
      bc_v[p]   = bc;
      din_v[p]  = {$urandom, $urandom};
      be_v[p]   = BW'($urandom_range(0, 255));
      we_v[p]   = 1'b1;
      exp_q.push_back({be_v[p], din_v[p]});
      wait_accept(p, ok);
      if (!ok) begin we_v[p] = 1'b0; return; end
    end
    we_v[p] = 1'b0;
  endtask

  task automatic m_read(input int p, input logic [7:0] bc, input logic [AW-1:0] addr,
                        output int beats);
    bit ok;
    beats     = 0;
    addr_v[p] = addr;
    bc_v[p]   = bc;
    rd_v[p]   = 1'b1;
    wait_accept(p, ok);
    rd_v[p] = 1'b0;
    if (!ok) return;
    for (int t = 0; t < 5000 && beats < blen(bc); t++) begin
      @(negedge clk);
      if (dr_v[p]) beats++;
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int na, nb, base;
    for (int p = 0; p < 2; p++) begin
      addr_v[p] = '0; bc_v[p] = '0; din_v[p] = '0; be_v[p] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // quiet after reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_owner", owner, 2'd0);
      chk("idle_busy", busy_v, 2'b11);
      chk("idle_cmd", {ddram_rd, ddram_we}, 2'b00);
    end

    // A write burst of 4 against a toggling ddram_busy
    @(posedge clk); #1;
    busy_mode = 1;
    base = wr_beats;
    m_write(0, 4, 8'd4, 29'h0123456);
    @(negedge clk);
    chk("wr_owner_back", owner, 2'd0);
    chk("wr_beat_count", wr_beats - base, 4);
    chk("wr_queue_empty", exp_q.size(), 0);
    busy_mode = 0;
    repeat (3) @(posedge clk); #1;

    // simultaneous reads of 8: A first, B only afterwards
    glog.delete();
    b_dr_while_a = 0;
    fork
      m_read(0, 8'd8, 29'h100, na);
      m_read(1, 8'd8, 29'h200, nb);
    join
    chk("ab_a_beats", na, 8);
    chk("ab_b_beats", nb, 8);
    chk("ab_grants", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("ab_first", glog[0], 1);
      chk("ab_second", glog[1], 2);
    end
    chk("ab_b_ready_in_a", b_dr_while_a, 0);
    repeat (3) @(posedge clk); #1;

    // B read of 256 beats, A write queued behind it
    glog.delete();
    busy_mode = 2;
    fork
      m_read(1, 8'd0, 29'h300, nb);
      begin
        repeat (5) @(posedge clk); #1;
        m_write(0, 2, 8'd2, 29'h400);
      end
    join
    chk("b256_beats", nb, 256);
    chk("b256_grants", glog.size(), 2);
    if (glog.size() >= 2) chk("b256_order", {glog[0][1:0], glog[1][1:0]}, 4'b10_01);
    busy_mode = 0;
    repeat (3) @(posedge clk); #1;

    // A requesting continuously, B read pending
    glog.delete();
    fork
      for (int i = 0; i < 6; i++) m_write(0, 1, 8'd1, 29'h500);
      m_read(1, 8'd1, 29'h600, nb);
    join
    chk("fair_b_beats", nb, 1);
    chk("fair_grants", glog.size(), 7);
    if (glog.size() >= 6) begin
`ifdef JTFRAME_DDRARB_FAIR_EN
      chk("fair_seq", {glog[0][1:0], glog[1][1:0], glog[2][1:0], glog[3][1:0],
                       glog[4][1:0], glog[5][1:0]}, 12'b01_01_01_01_10_01);
`else
      chk("fair_seq", {glog[0][1:0], glog[1][1:0], glog[2][1:0], glog[3][1:0],
                       glog[4][1:0], glog[5][1:0]}, 12'b01_01_01_01_01_01);
`endif
    end
    repeat (3) @(posedge clk); #1;

    // reset in the middle of a read data phase
    begin
      bit ok;
      addr_v[0] = 29'h700;
      bc_v[0]   = 8'd8;
      rd_v[0]   = 1'b1;
      wait_accept(0, ok);
      rd_v[0] = 1'b0;
      na = 0;
      for (int t = 0; t < 200 && na < 3; t++) begin
        @(negedge clk);
        if (a_dout_ready) na++;
      end
      chk("rst_pre_beats", na, 3);
      chk("rst_pre_owner", owner, 2'd1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rst_owner_now", owner, 2'd0);
      chk("rst_busy_now", busy_v, 2'b11);
      @(negedge clk);
      chk("rst_owner", owner, 2'd0);
      chk("rst_busy", busy_v, 2'b11);
      chk("rst_ready", dr_v, 2'b00);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_rst_owner", owner, 2'd0);
      chk("post_rst_cmd", {ddram_rd, ddram_we}, 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    n_fail++;
    $display("FAIL watchdog actual=running required=finished t=%0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
